// File: rtl/fc_pkg.sv
// Shared Fibre Channel definitions: link states, ordered-set words and the
// word-wide CRC-32 step used by the transmit framer and future receive checker.
package fc;

  typedef enum logic [2:0] {
    STATE_AC,
    STATE_LR,
    STATE_LRR,
    STATE_LF1,
    STATE_LF2,
    STATE_OL1,
    STATE_OL2,
    STATE_OL3
  } state_t;

  typedef enum logic [2:0] {
    TX_HOLDOFF,
    TX_IDLE,
    TX_DATA,
    TX_CRC,
    TX_EOF,
    TX_GAP,
    TX_DRAIN
  } tx_state_t;

  localparam logic [31:0] IDLE  = 32'hBC95B5B5;
  localparam logic [31:0] SOFI3 = 32'hBCB55656;
  localparam logic [31:0] SOFN3 = 32'hBCB53636;
  localparam logic [31:0] EOFT  = 32'hBC957575;
  localparam logic [31:0] EOFN  = 32'hBC95D5D5;
  localparam logic [31:0] EOFA  = 32'hBC95F5F5;

  localparam logic [3:0]  K_OS   = 4'b1000;
  localparam logic [3:0]  K_DATA = 4'b0000;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  // MSB-first: data bit 31 (first transmitted) enters the register first.
  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/fc_frame_tx_crc32.sv
// Combinational next-CRC for one 32-bit big-endian word.
module fc_crc32
  import fc::*;
(
  input  logic [31:0] i_crc,
  input  logic [31:0] i_data,
  output logic [31:0] o_crc
);

  assign o_crc = crc32_word(i_crc, i_data);

endmodule

// File: rtl/fc_frame_tx.sv
// 8GFC transmit framer: wraps Avalon-ST frame content in SOF/EOF, appends the
// complemented CRC-32 and fills everything else with IDLE, enforcing minimum gaps.
module fc_frame_tx
  import fc::*;
#(
  parameter int MIN_IDLES       = 6,
  parameter int MAX_FRAME_WORDS = 534
) (
  input  logic        clk,
  input  logic        reset,
  input  state_t      state,
  input  logic [31:0] avtx_data,
  input  logic        avtx_valid,
  input  logic        avtx_startofpacket,
  input  logic        avtx_endofpacket,
  output logic        avtx_ready,
  input  logic        avtx_sof_initiate,
  input  logic        avtx_eof_terminate,
  output logic [31:0] tx_data,
  output logic [3:0]  tx_datak,
  output logic [31:0] frames_sent,
  output logic [15:0] frames_aborted
);

  localparam int IW = $clog2(MIN_IDLES + 1);
  localparam int CW = $clog2(MAX_FRAME_WORDS + 1);

  tx_state_t         r_st, w_st_nx;
  logic [IW-1:0]     r_icnt, w_icnt_nx;
  logic [CW-1:0]     r_wcnt, w_wcnt_nx;
  logic              r_eoft, w_eoft_nx;
  logic              r_hold, w_hold_nx;
  logic [31:0]       r_crc, w_crc_nx, w_crc_fold;
  logic [31:0]       r_tx_data, w_tx_data_nx;
  logic [3:0]        r_tx_datak, w_tx_datak_nx;
  logic [31:0]       r_sent;
  logic [15:0]       r_aborted;
  logic              w_sent_inc, w_abort_inc, w_link;

  assign w_link = (state == STATE_AC);

  fc_crc32 u_crc (
    .i_crc  (r_crc),
    .i_data (avtx_data),
    .o_crc  (w_crc_fold)
  );

  // An SOP word is held in IDLE until SOF is out; stray non-SOP words are flushed.
  always_comb begin
    case (r_st)
      TX_IDLE:           avtx_ready = ~avtx_startofpacket;
      TX_DATA, TX_DRAIN: avtx_ready = 1'b1;
      default:           avtx_ready = 1'b0;
    endcase
  end

  always_comb begin
    w_st_nx       = r_st;
    w_icnt_nx     = r_icnt;
    w_wcnt_nx     = r_wcnt;
    w_eoft_nx     = r_eoft;
    w_hold_nx     = r_hold;
    w_crc_nx      = r_crc;
    w_tx_data_nx  = IDLE;
    w_tx_datak_nx = K_OS;
    w_sent_inc    = 1'b0;
    w_abort_inc   = 1'b0;
    case (r_st)
      TX_HOLDOFF, TX_GAP: begin
        if (!w_link) begin
          w_st_nx   = TX_HOLDOFF;
          w_icnt_nx = '0;
        end else if (r_icnt == IW'(MIN_IDLES - 1)) begin
          w_st_nx   = TX_IDLE;
          w_icnt_nx = '0;
        end else begin
          w_icnt_nx = r_icnt + 1'b1;
        end
      end
      TX_IDLE: begin
        if (!w_link) begin
          w_st_nx   = TX_HOLDOFF;
          w_icnt_nx = '0;
        end else if (avtx_valid && avtx_startofpacket) begin
          w_tx_data_nx = avtx_sof_initiate ? SOFI3 : SOFN3;
          w_st_nx      = TX_DATA;
          w_wcnt_nx    = '0;
          w_crc_nx     = CRC_INIT;
          w_hold_nx    = 1'b0;
        end
      end
      TX_DATA: begin
        if (!w_link) begin
          w_abort_inc = 1'b1;
          w_icnt_nx   = '0;
          if (avtx_valid && avtx_endofpacket) begin
            w_st_nx = TX_HOLDOFF;
          end else begin
            w_st_nx   = TX_DRAIN;
            w_hold_nx = 1'b1;
          end
        end else if (!avtx_valid || r_wcnt == CW'(MAX_FRAME_WORDS)) begin
          // Underrun or oversize: the word offered now (if any) is already part of the drain.
          w_tx_data_nx = EOFA;
          w_abort_inc  = 1'b1;
          w_icnt_nx    = '0;
          w_st_nx      = (avtx_valid && avtx_endofpacket) ? TX_GAP : TX_DRAIN;
        end else begin
          w_tx_data_nx  = avtx_data;
          w_tx_datak_nx = K_DATA;
          w_crc_nx      = w_crc_fold;
          w_wcnt_nx     = r_wcnt + 1'b1;
          if (avtx_endofpacket) begin
            w_st_nx   = TX_CRC;
            w_eoft_nx = avtx_eof_terminate;
          end
        end
      end
      TX_CRC: begin
        if (!w_link) begin
          w_abort_inc = 1'b1;
          w_st_nx     = TX_HOLDOFF;
          w_icnt_nx   = '0;
        end else begin
          w_tx_data_nx  = ~r_crc;
          w_tx_datak_nx = K_DATA;
          w_st_nx       = TX_EOF;
        end
      end
      TX_EOF: begin
        w_icnt_nx = '0;
        if (!w_link) begin
          w_abort_inc = 1'b1;
          w_st_nx     = TX_HOLDOFF;
        end else begin
          w_tx_data_nx = r_eoft ? EOFT : EOFN;
          w_sent_inc   = 1'b1;
          w_st_nx      = TX_GAP;
        end
      end
      TX_DRAIN: begin
        w_hold_nx = r_hold | ~w_link;
        if (avtx_valid && avtx_endofpacket) begin
          w_icnt_nx = '0;
          w_st_nx   = (r_hold || !w_link) ? TX_HOLDOFF : TX_GAP;
        end
      end
      default: begin
        w_st_nx   = TX_HOLDOFF;
        w_icnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st       <= TX_HOLDOFF;
      r_icnt     <= '0;
      r_wcnt     <= '0;
      r_eoft     <= 1'b0;
      r_hold     <= 1'b0;
      r_tx_data  <= IDLE;
      r_tx_datak <= K_OS;
      r_sent     <= '0;
      r_aborted  <= '0;
    end else begin
      r_st       <= w_st_nx;
      r_icnt     <= w_icnt_nx;
      r_wcnt     <= w_wcnt_nx;
      r_eoft     <= w_eoft_nx;
      r_hold     <= w_hold_nx;
      r_tx_data  <= w_tx_data_nx;
      r_tx_datak <= w_tx_datak_nx;
      if (w_sent_inc) r_sent <= r_sent + 32'd1;
      if (w_abort_inc && r_aborted != 16'hFFFF) r_aborted <= r_aborted + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    r_crc <= w_crc_nx;
  end

  assign tx_data        = r_tx_data;
  assign tx_datak       = r_tx_datak;
  assign frames_sent    = r_sent;
  assign frames_aborted = r_aborted;

endmodule
